filter_out_buffer: RTL and testbench
====================================

Name: filter_out_buffer

Overview:
- Output buffering stage directly downstream of the polyphase IIR filter top.
- Takes the 11-bit signed filter output sample stream in the fast clk domain. Each sample is qualified by a sample strobe.
- Discards the start-up transient samples after reset and buffers the rest in a FIFO.
- Presents samples to the consumer (DAC/stream sink) over a valid/ready handshake, with overflow detection and drop counting.

Parameters:
- DATA_W, 11, sample width; matches the filter output (sfix11).
- DEPTH, 16, FIFO entries; power of 2, ≥4.
- DISCARD_N, 24, accepted samples dropped after reset (filter pipeline/IIR settling).
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  fast sample clock, same clk as the filter output mux.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  strobe; `in` carries a valid filter sample this cycle.
- in  in  DATA_W  signed filter output sample.
- flush  in  1  synchronous; empties the FIFO.
- clear_ovf  in  1  synchronous; clears `overflow` and `drop_count`.
- out_data  out  DATA_W  signed head-of-FIFO sample.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- primed  out  1  discard phase complete.
- overflow  out  1  sticky; a sample was lost to a full FIFO.
- drop_count  out  CNT_W  count of samples lost to a full FIFO, saturating.

Behaviour:
- Single clock `clk`; reset is asynchronous and active-high, port `reset`. All flops clear on reset assertion.
- Reset values: out_data=0, out_valid=0, level=0, primed=0, overflow=0, drop_count=0. FSM in PRIME, discard counter=0, pointers=0.
- FSM states: PRIME, RUN.
  - PRIME: each in_valid increments the discard counter; the sample is dropped and not counted as overflow.
  - When the counter reaches DISCARD_N-1 and in_valid=1, that sample is dropped. Next state is RUN and `primed` goes to 1 in the following cycle.
  - DISCARD_N=0: the FSM resets into RUN and primed resets to 1.
- RUN behaviour:
  - push = in_valid; pop = out_valid & out_ready.
  - Push is accepted if level<DEPTH, or if level==DEPTH and pop=1 in the same cycle (the slot is freed the same cycle).
  - Push with level==DEPTH and pop=0: the sample is dropped, overflow←1, drop_count←drop_count+1, saturating at 2^CNT_W-1.
- Latency:
  - A sample pushed into an empty FIFO at edge N gives out_valid=1 with out_data=that sample after edge N, i.e. readable in cycle N+1.
  - Output is registered; there is no combinational path from `in` to `out_data`.
- Handshake:
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - After a pop, the next entry appears in the following cycle with no bubble if level>1.
  - out_ready while out_valid=0 has no effect.
- Ordering: samples leave in arrival order; sign and bit pattern are unmodified.
- level: tracks push/pop each cycle. Simultaneous push and pop leaves level unchanged.
- Pointer wrap: pointers wrap modulo DEPTH. Full vs empty is distinguished by the level counter or an extra pointer MSB.
- flush:
  - Next cycle: level=0 and out_valid=0.
  - A same-cycle in_valid is dropped and not counted.
  - FSM state and `primed` are unaffected.
- clear_ovf: next cycle overflow=0 and drop_count=0. If a drop happens in the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset mid-operation: all contents are lost, outputs return to reset values immediately, and the FSM returns to PRIME (discard restarts).
- No X propagation: out_data holds its last value when the FIFO is empty.

Test Plan:
- Reset, then in_valid every cycle with in=1,2,3,...; DISCARD_N=24 -> samples 1..24 never appear. primed rises after the 24th strobe; first out_data=25 with out_valid=1 one cycle after its push; out_ready=1 throughout gives 25,26,27... in order, level ≤1.
- After priming, out_ready=0 and 20 pushes of -1024..-1005 (DEPTH=16) -> level=16; samples -1008..-1005 dropped; overflow=1, drop_count=4. Then out_ready=1 -> exactly -1024..-1009 drained, level reaches 0, out_valid=0.
- Full FIFO with push and pop in the same cycle (in=+1023) -> no drop, level stays 16, drop_count unchanged; +1023 is the last sample drained.
- clear_ovf alone -> overflow=0, drop_count=0 next cycle. clear_ovf coincident with a full-FIFO drop -> overflow=1, drop_count=1.
- flush with level=9 and coincident in_valid -> next cycle level=0, out_valid=0; the coincident sample is never output; primed stays 1.
- Assert reset while level=5, out_valid=1 -> outputs return to reset values asynchronously (before the next edge). After release, the DISCARD_N samples are dropped again before any output.

Source files
------------

// File: rtl/filter_out_buffer.sv
// filter_out_buffer: output buffer behind the polyphase IIR filter.
// Drops the first DISCARD_N strobed samples after reset while the filter
// settles. After that it queues samples in a DEPTH-entry FIFO and hands them
// to the consumer over a valid/ready handshake. Samples that arrive when the
// FIFO is full are counted as overflow drops.
module filter_out_buffer #(
    parameter int DATA_W    = 11,
    parameter int DEPTH     = 16,
    parameter int DISCARD_N = 24,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in,
    input  logic                       flush,
    input  logic                       clear_ovf,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       primed,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int DC_W  = (DISCARD_N > 1) ? $clog2(DISCARD_N) : 1;
    localparam int DLAST = (DISCARD_N > 0) ? DISCARD_N - 1 : 0;

    typedef enum logic {PRIME, RUN} state_t;

    state_t              state, state_nxt;
    logic [DC_W-1:0]     disc_cnt, disc_cnt_nxt;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [LVL_W-1:0]    level_nxt;

    logic run, pop, full, push_req, push, drop, head_from_in;

    // ---------------------------------------------------------------
    // Discard-phase FSM
    // ---------------------------------------------------------------

    // State register; with no discard phase the block comes out of reset running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= (DISCARD_N == 0) ? RUN : PRIME;
            disc_cnt <= '0;
        end else begin
            state    <= state_nxt;
            disc_cnt <= disc_cnt_nxt;
        end
    end

    // Count strobes in PRIME. The strobe that brings the count to DISCARD_N moves the FSM to RUN.
    always_comb begin
        state_nxt    = state;
        disc_cnt_nxt = disc_cnt;
        case (state)
            PRIME: begin
                if (in_valid) begin
                    if (disc_cnt == DC_W'(DLAST)) begin
                        state_nxt = RUN;
                    end else begin
                        disc_cnt_nxt = disc_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: state_nxt = PRIME;
        endcase
    end

    assign run    = (state == RUN);
    assign primed = run;

    // ---------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------
    // A full FIFO still accepts a push when a pop frees a slot in the same
    // cycle. Flush suppresses both the push and the drop accounting.
    assign pop      = out_valid & out_ready;
    assign full     = (level == LVL_W'(DEPTH));
    assign push_req = run & in_valid & ~flush;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // The new head comes straight from `in` when the FIFO is (or becomes) empty this cycle.
    assign head_from_in = push & ((level == '0) | ((level == LVL_W'(1)) & pop));

    // Next-cycle pointers and occupancy.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            wr_ptr_nxt = wr_ptr + AW'(push);
            rd_ptr_nxt = rd_ptr + AW'(pop);
            level_nxt  = level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
        end
    end

    // Sample storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    // Registered head-of-FIFO. out_data keeps its last value while the FIFO is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (level_nxt != '0);
            if (head_from_in) begin
                out_data <= in;
            end else if (level_nxt != '0) begin
                out_data <= mem[rd_ptr_nxt];
            end
        end
    end

    // Overflow flag and saturating drop counter. A same-cycle drop overrides clear_ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clear_ovf) begin
                drop_count <= CNT_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_filter_out_buffer.sv
// Self-checking bench for filter_out_buffer: a table of post-reset vectors,
// directed corner sequences, then random traffic against a queue-based model.
module tb_filter_out_buffer;

    localparam int DATA_W    = 11;
    localparam int DEPTH     = 16;
    localparam int DISCARD_N = 24;
    localparam int CNT_W     = 16;
    localparam int LVL_W     = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] din = '0;
    logic                     flush = 1'b0;
    logic                     clear_ovf = 1'b0;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [LVL_W-1:0]         level;
    logic                     primed;
    logic                     overflow;
    logic [CNT_W-1:0]         drop_count;

    always #5 clk = ~clk;

    filter_out_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DISCARD_N(DISCARD_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
        .flush(flush), .clear_ovf(clear_ovf),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .primed(primed), .overflow(overflow), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered samples plus the status it implies.
    int q[$];
    bit m_primed;
    int m_disc;
    bit m_ovf;
    int m_dc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_primed = (DISCARD_N == 0);
        m_disc   = 0;
        m_ovf    = 0;
        m_dc     = 0;
    endfunction

    function automatic void model_step();
        bit pop;
        bit drop;
        bit was_primed;
        drop       = 0;
        was_primed = m_primed;
        pop        = (q.size() > 0) && out_ready;
        if (!was_primed && in_valid) begin
            m_disc++;
            if (m_disc == DISCARD_N) m_primed = 1;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (in_valid && was_primed) begin
                if (q.size() < DEPTH) q.push_back(int'(din));
                else drop = 1;
            end
        end
        if (clear_ovf) begin
            m_ovf = 0;
            m_dc  = 0;
        end
        if (drop) begin
            m_ovf = 1;
            if (m_dc < (1 << CNT_W) - 1) m_dc++;
        end
    endfunction

    task automatic check_outs();
        chk("out_valid", int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) chk("out_data", int'(out_data), q[0]);
        chk("level", int'(level), q.size());
        chk("primed", int'(primed), int'(m_primed));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_count", int'(drop_count), m_dc);
    endtask

    // One clock: model follows the edge, outputs compared 1ns later.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        check_outs();
    endtask

    task automatic fill(input int n, input int base);
        out_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            din = DATA_W'(base + k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic iv;
        int   d;
        logic rdy;
        logic ev;
        int   ed;
        int   el;
        logic ep;
    } vec_t;

    vec_t tbl[30];

    initial begin
        // Post-reset vectors: strobe 1..30 with out_ready held high.
        for (int i = 0; i < 30; i++) begin
            tbl[i].iv  = 1'b1;
            tbl[i].d   = i + 1;
            tbl[i].rdy = 1'b1;
            if (i < DISCARD_N) begin
                tbl[i].ev = 1'b0;
                tbl[i].ed = 0;
                tbl[i].el = 0;
                tbl[i].ep = (i == DISCARD_N - 1);
            end else begin
                tbl[i].ev = 1'b1;
                tbl[i].ed = i + 1;
                tbl[i].el = 1;
                tbl[i].ep = 1'b1;
            end
        end

        model_reset();
        #12;
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_primed", int'(primed), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Priming and first outputs.
        for (int i = 0; i < 30; i++) begin
            in_valid  = tbl[i].iv;
            din       = DATA_W'(tbl[i].d);
            out_ready = tbl[i].rdy;
            tick();
            chk("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            chk("tbl_level", int'(level), tbl[i].el);
            chk("tbl_primed", int'(primed), int'(tbl[i].ep));
            if (tbl[i].ev) chk("tbl_data", int'(out_data), tbl[i].ed);
        end
        drain(1);

        // Overflow: 20 pushes into 16 slots with no consumer.
        fill(20, -1024);
        chk("ovf_level", int'(level), 16);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(drop_count), 4);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("ovf_drain_data", int'(out_data), -1024 + k);
            tick();
        end
        chk("ovf_empty_valid", int'(out_valid), 0);
        chk("ovf_empty_level", int'(level), 0);

        // Full FIFO with a simultaneous push and pop.
        fill(16, 0);
        in_valid  = 1'b1;
        din       = 11'sd1023;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fullpp_level", int'(level), 16);
        chk("fullpp_count", int'(drop_count), 4);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("fullpp_last", int'(out_data), 1023);
            tick();
        end
        out_ready = 1'b0;

        // clear_ovf alone, then clear_ovf colliding with a drop.
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("clr_flag", int'(overflow), 0);
        chk("clr_count", int'(drop_count), 0);
        fill(16, 50);
        in_valid  = 1'b1;
        din       = 11'sd5;
        clear_ovf = 1'b1;
        tick();
        in_valid  = 1'b0;
        clear_ovf = 1'b0;
        chk("clrdrop_flag", int'(overflow), 1);
        chk("clrdrop_count", int'(drop_count), 1);
        drain(16);

        // Flush at level 9 with a coincident strobe.
        fill(9, 100);
        chk("flush_pre_level", int'(level), 9);
        flush    = 1'b1;
        in_valid = 1'b1;
        din      = 11'sd77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_primed", int'(primed), 1);
        drain(2);
        chk("flush_no77", int'(out_valid), 0);

        // Reset in the middle of operation.
        fill(5, 200);
        chk("mid_level", int'(level), 5);
        chk("mid_valid", int'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_primed", int'(primed), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_drop_count", int'(drop_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            din = DATA_W'(300 + k);
            tick();
            if (k == DISCARD_N - 2) chk("reprime_not_yet", int'(primed), 0);
            if (k == DISCARD_N - 1) chk("reprime_valid0", int'(out_valid), 0);
            if (k == DISCARD_N) chk("reprime_first", int'(out_data), 300 + DISCARD_N);
        end

        // Random traffic with alternating consumer bias to reach full/empty.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            din       = DATA_W'($urandom());
            if ((n / 150) % 2 == 0) out_ready = ($urandom_range(0, 3) == 0);
            else                    out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            clear_ovf = ($urandom_range(0, 59) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        clear_ovf = 1'b0;
        drain(DEPTH + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
